// File: rtl/bp_ctrl_pkg.sv
// Shared encodings for the backprop MAC sequencer: delta/weight modes,
// gate indices and the sequencer state type.
package bp_ctrl_pkg;

  localparam logic [1:0] MODE_DX2   = 2'd0;
  localparam logic [1:0] MODE_DOUT2 = 2'd1;
  localparam logic [1:0] MODE_DOUT1 = 2'd2;
  localparam logic [1:0] MODE_ILL   = 2'd3;

  localparam logic [1:0] GATE_A = 2'd0;
  localparam logic [1:0] GATE_I = 2'd1;
  localparam logic [1:0] GATE_F = 2'd2;
  localparam logic [1:0] GATE_O = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/bp_loop_cnt.sv
// Loadable up-counter with a terminal-count flag (cnt_o == last_i).
// Used for the gate, column and row loops and the drain timer.
module bp_loop_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // Load has priority over count enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (en_i)   cnt_q <= cnt_q + W'(1);
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/bp_mac_ctrl.sv
// Backprop MAC path sequencer: one matrix-vector pass per start.
// Per row: CLR, 4*cols MAC cycles, MAC_LAT drain cycles, one WRITE.
// Optional feature macro: BP_MAC_CTRL_PERF_EN (busy-cycle counter on o_perf_cycles).
module bp_mac_ctrl
  import bp_ctrl_pkg::*;
#(
  parameter int ADDR    = 12,
  parameter int MAC_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [1:0]      i_mode,
  input  logic [ADDR-1:0] i_rows,
  input  logic [ADDR-1:0] i_cols,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic            o_rst_mac,
  output logic            o_acc_mac,
  output logic [1:0]      o_sel_dgate,
  output logic            o_sel_wght,
  output logic [1:0]      o_sel_wghts1,
  output logic [2:0]      o_sel_wghts2,
  output logic [ADDR-1:0] o_rd_addr_w,
  output logic [ADDR-1:0] o_rd_addr_g,
  output logic            o_wr_dx2,
  output logic            o_wr_dout2,
  output logic            o_wr_dout1,
  output logic [ADDR-1:0] o_wr_addr,
  output logic [31:0]     o_perf_cycles
);

  localparam logic [2:0] DRAIN_LAST = 3'(MAC_LAT - 1);

  state_t          state_q, state_d;
  logic [1:0]      mode_q;
  logic [ADDR-1:0] rows_q, cols_q;
  logic [ADDR-1:0] addr_w_q;

  logic            accept, degenerate;
  logic            in_mac, in_drain, in_write;
  logic            mac_end, drain_done, next_row;

  logic [1:0]      g_cnt;
  logic            g_tc;
  logic [ADDR-1:0] c_cnt, row_cnt;
  logic            c_tc, row_tc, d_tc;
  logic [2:0]      drain_cnt_unused;

  assign accept     = (state_q == ST_IDLE) && i_start;
  assign degenerate = (i_rows == '0) || (i_cols == '0) || (i_mode == MODE_ILL);
  assign in_mac     = (state_q == ST_MAC);
  assign in_drain   = (state_q == ST_DRAIN);
  assign in_write   = (state_q == ST_WRITE);
  // Loop counters hold their last value at the final MAC cycle so the
  // select/address outputs stay stable through DRAIN and WRITE.
  assign mac_end    = in_mac && g_tc && c_tc;
  assign drain_done = in_drain && d_tc;
  assign next_row   = in_write && !row_tc;

  bp_loop_cnt #(.W(2)) u_gate_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept || next_row),
    .load_val_i (GATE_A),
    .en_i       (in_mac && !mac_end),
    .last_i     (GATE_O),
    .cnt_o      (g_cnt),
    .tc_o       (g_tc)
  );

  bp_loop_cnt #(.W(ADDR)) u_col_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept || next_row),
    .load_val_i ('0),
    .en_i       (in_mac && g_tc && !c_tc),
    .last_i     (cols_q - ADDR'(1)),
    .cnt_o      (c_cnt),
    .tc_o       (c_tc)
  );

  bp_loop_cnt #(.W(ADDR)) u_row_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i ('0),
    .en_i       (next_row),
    .last_i     (rows_q - ADDR'(1)),
    .cnt_o      (row_cnt),
    .tc_o       (row_tc)
  );

  bp_loop_cnt #(.W(3)) u_drain_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (mac_end),
    .load_val_i ('0),
    .en_i       (in_drain),
    .last_i     (DRAIN_LAST),
    .cnt_o      (drain_cnt_unused),
    .tc_o       (d_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_start) state_d = degenerate ? ST_FIN : ST_CLR;
      ST_CLR:   state_d = ST_MAC;
      ST_MAC:   if (mac_end) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_d = ST_WRITE;
      ST_WRITE: state_d = row_tc ? ST_FIN : ST_CLR;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pass parameters are captured only at start accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_DX2;
      rows_q <= '0;
      cols_q <= '0;
    end else if (accept) begin
      mode_q <= i_mode;
      rows_q <= i_rows;
      cols_q <= i_cols;
    end
  end

  // Weight address = row*cols + c, built by incrementing: +1 on each column
  // step and +1 when moving to the next row (covers the final column).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              addr_w_q <= '0;
    else if (accept)                      addr_w_q <= '0;
    else if (in_mac && g_tc && !c_tc)     addr_w_q <= addr_w_q + ADDR'(1);
    else if (next_row)                    addr_w_q <= addr_w_q + ADDR'(1);
  end

  assign o_busy       = (state_q == ST_CLR) || in_mac || in_drain || in_write;
  assign o_done       = (state_q == ST_FIN);
  assign o_err        = o_done && (mode_q == MODE_ILL);
  assign o_rst_mac    = (state_q == ST_CLR);
  assign o_acc_mac    = in_mac;
  assign o_sel_dgate  = g_cnt;
  assign o_sel_wght   = (mode_q == MODE_DOUT1);
  assign o_sel_wghts1 = g_cnt;
  assign o_sel_wghts2 = {(mode_q == MODE_DOUT2), g_cnt};
  assign o_rd_addr_w  = addr_w_q;
  assign o_rd_addr_g  = c_cnt;
  assign o_wr_dx2     = in_write && (mode_q == MODE_DX2);
  assign o_wr_dout2   = in_write && (mode_q == MODE_DOUT2);
  assign o_wr_dout1   = in_write && (mode_q == MODE_DOUT1);
  assign o_wr_addr    = row_cnt;

`ifdef BP_MAC_CTRL_PERF_EN
  logic [31:0] perf_q;

  // Busy-cycle counter: cleared at start accept, holds after the pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         perf_q <= '0;
    else if (accept) perf_q <= '0;
    else if (o_busy) perf_q <= perf_q + 32'd1;
  end

  assign o_perf_cycles = perf_q;
`else
  assign o_perf_cycles = '0;
`endif

endmodule

// File: tb/tb_bp_mac_ctrl.sv
// Self-checking bench for bp_mac_ctrl: table of passes plus a mid-pass
// reset sequence; per-cycle MAC operands and write events are predicted
// into queues when a pass is launched and popped as the DUT produces them.
module tb_bp_mac_ctrl;

  localparam int ADDR = 12;
  localparam int LAT  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_start;
  logic [1:0]      i_mode;
  logic [ADDR-1:0] i_rows, i_cols;
  logic            o_busy, o_done, o_err, o_rst_mac, o_acc_mac;
  logic [1:0]      o_sel_dgate, o_sel_wghts1;
  logic            o_sel_wght;
  logic [2:0]      o_sel_wghts2;
  logic [ADDR-1:0] o_rd_addr_w, o_rd_addr_g, o_wr_addr;
  logic            o_wr_dx2, o_wr_dout2, o_wr_dout1;
  logic [31:0]     o_perf_cycles;

  bp_mac_ctrl #(.ADDR(ADDR), .MAC_LAT(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_mode        (i_mode),
    .i_rows        (i_rows),
    .i_cols        (i_cols),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_rst_mac     (o_rst_mac),
    .o_acc_mac     (o_acc_mac),
    .o_sel_dgate   (o_sel_dgate),
    .o_sel_wght    (o_sel_wght),
    .o_sel_wghts1  (o_sel_wghts1),
    .o_sel_wghts2  (o_sel_wghts2),
    .o_rd_addr_w   (o_rd_addr_w),
    .o_rd_addr_g   (o_rd_addr_g),
    .o_wr_dx2      (o_wr_dx2),
    .o_wr_dout2    (o_wr_dout2),
    .o_wr_dout1    (o_wr_dout1),
    .o_wr_addr     (o_wr_addr),
    .o_perf_cycles (o_perf_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int rows;
    int cols;
    bit disturb;
    int exp_lat;   // cycles from start accept to o_done
    bit exp_err;
  } vec_t;

  typedef struct { int g; int c; int aw; } mac_t;
  typedef struct { int mode; int row; int cyc; } wr_t;

  mac_t mq[$];
  wr_t  wq[$];
  vec_t vecs[7];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [63:0] packed_outs;
    packed_outs = {o_busy, o_done, o_err, o_rst_mac, o_acc_mac, o_sel_dgate,
                   o_sel_wght, o_sel_wghts1, o_sel_wghts2, o_rd_addr_w,
                   o_rd_addr_g, o_wr_dx2, o_wr_dout2, o_wr_dout1, o_wr_addr};
    check({name, "_ctl"}, {31'd0, |packed_outs}, 32'd0);
    check({name, "_perf"}, o_perf_cycles, 32'd0);
  endtask

  task automatic run_pass(input int mode, input int rows, input int cols,
                          input bit disturb, input int exp_lat, input bit exp_err);
    bit   degen, done_seen;
    int   busy, nclr, exp_busy, last_aw, last_g, last_c;
    mac_t m;
    wr_t  w;
    logic [2:0] exp_strobe;
    mq.delete();
    wq.delete();
    degen    = (rows == 0) || (cols == 0) || (mode == 3);
    exp_busy = degen ? 0 : rows * (4 * cols + LAT + 2);
    if (!degen)
      for (int r = 0; r < rows; r++) begin
        for (int c = 0; c < cols; c++)
          for (int g = 0; g < 4; g++)
            mq.push_back('{g, c, r * cols + c});
        wq.push_back('{mode, r, (r + 1) * (4 * cols + LAT + 2)});
      end
    @(negedge clk);
    i_start = 1'b1;
    i_mode  = 2'(mode);
    i_rows  = ADDR'(rows);
    i_cols  = ADDR'(cols);
    busy = 0; nclr = 0; done_seen = 0; last_aw = 0; last_g = 0; last_c = 0;
    for (int k = 1; k <= 300 && !done_seen; k++) begin
      @(negedge clk);
      if (k == 1) i_start = 1'b0;
      if (disturb && k == 5) begin
        i_start = 1'b1; i_mode = 2'd2; i_cols = ADDR'(5); i_rows = ADDR'(7);
      end
      if (disturb && k == 6) i_start = 1'b0;
      if (o_busy)    busy++;
      if (o_rst_mac) nclr++;
      if (o_acc_mac) begin
        if (mq.size() == 0) check("mac_extra_cycle", 32'd1, 32'd0);
        else begin
          m = mq.pop_front();
          check("sel_dgate", {30'd0, o_sel_dgate}, m.g);
          check("sel_wghts1", {30'd0, o_sel_wghts1}, m.g);
          check("sel_wghts2_gate", {30'd0, o_sel_wghts2[1:0]}, m.g);
          check("rd_addr_g", {20'd0, o_rd_addr_g}, m.c);
          check("rd_addr_w", {20'd0, o_rd_addr_w}, m.aw);
          check("sel_wght", {31'd0, o_sel_wght}, (mode == 2) ? 1 : 0);
          if (mode != 2) check("sel_wghts2_uw", {31'd0, o_sel_wghts2[2]}, (mode == 1) ? 1 : 0);
          last_aw = m.aw; last_g = m.g; last_c = m.c;
        end
      end else if (o_busy && !o_rst_mac) begin
        check("hold_addr_w", {20'd0, o_rd_addr_w}, last_aw);
        check("hold_dgate", {30'd0, o_sel_dgate}, last_g);
        check("hold_addr_g", {20'd0, o_rd_addr_g}, last_c);
      end
      if (o_wr_dx2 || o_wr_dout2 || o_wr_dout1) begin
        if (wq.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else begin
          w = wq.pop_front();
          exp_strobe = (w.mode == 0) ? 3'b100 : (w.mode == 1) ? 3'b010 : 3'b001;
          check("wr_strobe", {29'd0, o_wr_dx2, o_wr_dout2, o_wr_dout1}, {29'd0, exp_strobe});
          check("wr_addr", {20'd0, o_wr_addr}, w.row);
          check("wr_cycle", k, w.cyc);
        end
      end
      if (o_err && !o_done) check("err_without_done", 32'd1, 32'd0);
      if (o_done) begin
        done_seen = 1;
        check("done_latency", k, exp_lat);
        check("done_err", {31'd0, o_err}, {31'd0, exp_err});
        check("busy_cycles", busy, exp_busy);
        check("clr_count", nclr, degen ? 0 : rows);
        check("mac_left", mq.size(), 0);
        check("wr_left", wq.size(), 0);
      end
    end
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, o_done}, 32'd0);
    check("busy_after", {31'd0, o_busy}, 32'd0);
`ifdef BP_MAC_CTRL_PERF_EN
    check("perf_after_done", o_perf_cycles, exp_busy);
    repeat (4) @(negedge clk);
    check("perf_hold", o_perf_cycles, exp_busy);
`else
    check("perf_tied", o_perf_cycles, 32'd0);
    repeat (4) @(negedge clk);
`endif
  endtask

  initial begin
    // mode, rows, cols, disturb, latency = rows*(4*cols+LAT+2)+1 (or 1), err
    vecs[0] = '{0, 2, 3, 1'b0, 33, 1'b0};
    vecs[1] = '{2, 1, 1, 1'b0,  9, 1'b0};
    vecs[2] = '{1, 3, 2, 1'b0, 37, 1'b0};
    vecs[3] = '{0, 0, 3, 1'b0,  1, 1'b0};
    vecs[4] = '{3, 2, 2, 1'b0,  1, 1'b1};
    vecs[5] = '{1, 2, 0, 1'b0,  1, 1'b0};
    vecs[6] = '{0, 2, 3, 1'b1, 33, 1'b0};

    rst = 1'b1; i_start = 1'b0; i_mode = '0; i_rows = '0; i_cols = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    for (int i = 0; i < 7; i++)
      run_pass(vecs[i].mode, vecs[i].rows, vecs[i].cols, vecs[i].disturb,
               vecs[i].exp_lat, vecs[i].exp_err);

    // Async reset during row 0 drain (cycles 14..15 for cols=3, LAT=2).
    @(negedge clk);
    i_start = 1'b1; i_mode = 2'd0; i_rows = ADDR'(2); i_cols = ADDR'(3);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) i_start = 1'b0;
    end
    check("pre_rst_in_drain", {30'd0, o_busy, o_acc_mac}, 32'd2);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    check_all_zero("rst_held");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_rst");
    run_pass(0, 2, 3, 1'b0, 33, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
